// File: rtl/crc_serial_engine.sv
// Serial LFSR CRC engine: absorbs a LSB-first message, then either shifts the
// remainder out (generate) or flags a non-zero residue (check).
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | LFSR holds SEED, waiting for the first accepted bit of a frame
// S_ABSORB| shifting message (and, in check mode, appended CRC) bits in
// S_EMIT  | generate only: remainder driven out on CRC with Valid
module crc_serial_engine #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  POLY      = 8'hC4,
    parameter logic [WIDTH-1:0]  SEED      = 8'hD8,
    parameter int                DATA_BITS = 8
) (
    input  logic CLK,
    input  logic RST,
    input  logic DATA,
    input  logic ACTIVE,
    input  logic MODE,
    output logic CRC,
    output logic Valid,
    output logic BUSY,
    output logic DONE,
    output logic CRC_ERR
);

    localparam int            CW       = $clog2(DATA_BITS + WIDTH + 1);
    localparam logic [CW-1:0] GEN_LAST = CW'(DATA_BITS);
    localparam logic [CW-1:0] CHK_LAST = CW'(DATA_BITS + WIDTH);
    localparam logic [CW-1:0] OUT_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ABSORB = 2'd1,
        S_EMIT   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CW-1:0]     out_cnt_q, out_cnt_d;
    logic              mode_q, mode_d;
    logic              crc_q, crc_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              fb;
    logic [WIDTH-1:0]  lfsr_step;
    logic [CW-1:0]     bit_cnt_inc;

    // Right shift with zero fill places POLY[WIDTH-1] & fb into the top bit.
    assign fb          = lfsr_q[0] ^ DATA;
    assign lfsr_step   = (lfsr_q >> 1) ^ (POLY & {WIDTH{fb}});
    assign bit_cnt_inc = bit_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        bit_cnt_d = bit_cnt_q;
        out_cnt_d = out_cnt_q;
        mode_d    = mode_q;
        crc_d     = 1'b0;
        valid_d   = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;

        case (state_q)
            S_IDLE: begin
                if (ACTIVE) begin
                    lfsr_d    = lfsr_step;
                    mode_d    = MODE;
                    err_d     = 1'b0;
                    bit_cnt_d = CW'(1);
                    if (DATA_BITS == 1 && !MODE) begin
                        state_d = S_EMIT;
                    end else begin
                        state_d = S_ABSORB;
                    end
                end
            end

            S_ABSORB: begin
                if (ACTIVE) begin
                    lfsr_d    = lfsr_step;
                    bit_cnt_d = bit_cnt_inc;
                    if (!mode_q && bit_cnt_inc == GEN_LAST) begin
                        state_d = S_EMIT;
                    end else if (mode_q && bit_cnt_inc == CHK_LAST) begin
                        // A correctly appended remainder leaves the register all-zero.
                        err_d     = |lfsr_step;
                        done_d    = 1'b1;
                        lfsr_d    = SEED;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end
                end
            end

            S_EMIT: begin
                if (out_cnt_q == OUT_LAST) begin
                    done_d    = 1'b1;
                    lfsr_d    = SEED;
                    bit_cnt_d = '0;
                    out_cnt_d = '0;
                    state_d   = S_IDLE;
                end else begin
                    crc_d     = lfsr_q[0];
                    valid_d   = 1'b1;
                    lfsr_d    = lfsr_q >> 1;
                    out_cnt_d = out_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= S_IDLE;
            lfsr_q    <= SEED;
            bit_cnt_q <= '0;
            out_cnt_q <= '0;
            mode_q    <= 1'b0;
            crc_q     <= 1'b0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lfsr_q    <= lfsr_d;
            bit_cnt_q <= bit_cnt_d;
            out_cnt_q <= out_cnt_d;
            mode_q    <= mode_d;
            crc_q     <= crc_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign CRC     = crc_q;
    assign Valid   = valid_q;
    assign BUSY    = (state_q != S_IDLE);
    assign DONE    = done_q;
    assign CRC_ERR = err_q;

endmodule

// File: tb/tb_crc_serial_engine.sv
// Directed bench for crc_serial_engine: default 8-bit instance plus a
// CRC-16 (0xA001 reflected, seed 0xFFFF) instance.
module tb_crc_serial_engine;

    logic CLK = 1'b0;
    logic RST;
    logic d8_data, d8_act, d8_mode;
    logic d8_crc, d8_valid, d8_busy, d8_done, d8_err;
    logic d16_data, d16_act, d16_mode;
    logic d16_crc, d16_valid, d16_busy, d16_done, d16_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit saw_valid;

    always #5 CLK = ~CLK;

    crc_serial_engine u_dut8 (
        .CLK(CLK), .RST(RST), .DATA(d8_data), .ACTIVE(d8_act), .MODE(d8_mode),
        .CRC(d8_crc), .Valid(d8_valid), .BUSY(d8_busy), .DONE(d8_done), .CRC_ERR(d8_err)
    );

    crc_serial_engine #(
        .WIDTH(16), .POLY(16'hA001), .SEED(16'hFFFF), .DATA_BITS(16)
    ) u_dut16 (
        .CLK(CLK), .RST(RST), .DATA(d16_data), .ACTIVE(d16_act), .MODE(d16_mode),
        .CRC(d16_crc), .Valid(d16_valid), .BUSY(d16_busy), .DONE(d16_done), .CRC_ERR(d16_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] crc16_ref(input logic [15:0] msg);
        logic [15:0] r;
        r = 16'hFFFF;
        for (int i = 0; i < 16; i++) begin
            if (r[0] ^ msg[i]) r = (r >> 1) ^ 16'hA001;
            else               r = r >> 1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
        cyc++;
        if (d8_valid || d16_valid) saw_valid = 1'b1;
    endtask

    task automatic drive(input bit sel, input logic d, input logic act, input logic m);
        if (sel) begin
            d16_data = d; d16_act = act; d16_mode = m;
        end else begin
            d8_data = d; d8_act = act; d8_mode = m;
        end
    endtask

    task automatic send_bits(input bit sel, input logic m, input logic [31:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            drive(sel, bits[i], 1'b1, m);
            tick();
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic collect(input bit sel, input bit pulse, output logic [31:0] crc,
                           output int nvalid, output int first_cyc, output int done_cyc,
                           output bit contig);
        int   last;
        logic v, c, dn;
        crc = '0; nvalid = 0; first_cyc = -1; done_cyc = -1; last = -1; contig = 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (pulse) drive(sel, 1'b1, 1'b1, 1'b1);
            tick();
            v  = sel ? d16_valid : d8_valid;
            c  = sel ? d16_crc   : d8_crc;
            dn = sel ? d16_done  : d8_done;
            if (v) begin
                if (last >= 0 && last != cyc - 1) contig = 1'b0;
                if (first_cyc < 0) first_cyc = cyc;
                last = cyc;
                if (nvalid < 32) crc[nvalid] = c;
                nvalid++;
            end
            if (dn) begin
                done_cyc = cyc;
                break;
            end
        end
        drive(sel, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] crc;
        logic [15:0] exp16;
        int nv, first, done_at, t0, cnt;
        bit contig, saw_done;

        drive(0, 0, 0, 0);
        drive(1, 0, 0, 0);
        RST = 1'b1;
        tick();
        tick();
        chk("reset_outs8",  {d8_crc, d8_valid, d8_busy, d8_done, d8_err}, 0);
        chk("reset_outs16", {d16_crc, d16_valid, d16_busy, d16_done, d16_err}, 0);
        RST = 1'b0;
        tick();

        // Generate, zero message
        t0 = cyc;
        send_bits(0, 0, 32'h0, 8);
        chk("gen_busy_after_last_bit", d8_busy, 1);
        chk("gen_valid_not_yet", d8_valid, 0);
        collect(0, 0, crc, nv, first, done_at, contig);
        chk("gen_crc", crc, 32'h14);
        chk("gen_nvalid", nv, 8);
        chk("gen_contig", contig, 1);
        chk("gen_valid_onset", first - t0, 9);
        chk("gen_done_at", done_at - t0, 17);
        chk("gen_busy_at_done", d8_busy, 0);
        tick();
        chk("gen_done_one_cycle", d8_done, 0);

        // Check mode, correct appended remainder
        saw_valid = 1'b0;
        send_bits(0, 1, 32'h1400, 16);
        chk("chk_ok_done", d8_done, 1);
        chk("chk_ok_err", d8_err, 0);
        chk("chk_ok_no_valid", saw_valid, 0);
        chk("chk_ok_busy", d8_busy, 0);

        // Check mode, fourth CRC bit flipped
        send_bits(0, 1, 32'h1C00, 16);
        chk("chk_bad_done", d8_done, 1);
        chk("chk_bad_err", d8_err, 1);
        idle(5);
        chk("chk_bad_err_held", d8_err, 1);

        // Stalled generate frame; first bit also clears CRC_ERR
        t0 = cyc;
        send_bits(0, 0, 32'h0, 1);
        chk("err_cleared_by_new_frame", d8_err, 0);
        send_bits(0, 0, 32'h0, 3);
        idle(3);
        send_bits(0, 0, 32'h0, 4);
        collect(0, 0, crc, nv, first, done_at, contig);
        chk("stall_crc", crc, 32'h14);
        chk("stall_nvalid", nv, 8);
        chk("stall_valid_onset", first - t0, 12);

        // Reset in the middle of emission
        send_bits(0, 0, 32'h0, 8);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (d8_valid) cnt++;
            if (cnt == 3) break;
        end
        chk("rst_third_valid_seen", cnt, 3);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk("rst_mid_emit_outs", {d8_crc, d8_valid, d8_busy, d8_done}, 0);
        saw_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (d8_done) saw_done = 1'b1;
        end
        chk("rst_no_done", saw_done, 0);
        send_bits(0, 0, 32'h0, 8);
        collect(0, 0, crc, nv, first, done_at, contig);
        chk("rst_reseed_crc", crc, 32'h14);
        chk("rst_reseed_nvalid", nv, 8);

        // Back-to-back frames, ACTIVE pulses during the second emission
        send_bits(0, 0, 32'h0, 8);
        collect(0, 0, crc, nv, first, done_at, contig);
        chk("b2b_first_crc", crc, 32'h14);
        t0 = cyc;
        send_bits(0, 0, 32'h01, 8);
        collect(0, 1, crc, nv, first, done_at, contig);
        chk("b2b_second_crc", crc, 32'hBF);
        chk("b2b_second_nvalid", nv, 8);
        chk("b2b_second_onset", first - t0, 9);
        chk("b2b_second_done_at", done_at - t0, 17);

        send_bits(0, 1, 32'hBF01, 16);
        chk("chk_01_done", d8_done, 1);
        chk("chk_01_err", d8_err, 0);

        // 16-bit instance
        exp16 = crc16_ref(16'h1234);
        send_bits(1, 0, 32'h1234, 16);
        collect(1, 0, crc, nv, first, done_at, contig);
        chk("w16_crc", crc, {16'h0, exp16});
        chk("w16_nvalid", nv, 16);
        chk("w16_contig", contig, 1);
        send_bits(1, 1, {exp16, 16'h1234}, 32);
        chk("w16_chk_done", d16_done, 1);
        chk("w16_chk_err", d16_err, 0);

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
